// File: rtl/scene_link_pkg.sv
// rtl/scene_link_pkg.sv - shared constants, payload/triangle types and unpack helper for the scene link
package scene_link_pkg;

    localparam int          PAYLOAD_BYTES = 38;
    localparam int          PAYLOAD_W     = 8 * PAYLOAD_BYTES;
    localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
    localparam logic [7:0]  TYPE_TRI      = 8'h01;
    localparam logic [7:0]  TYPE_EOF      = 8'h02;

    typedef logic [PAYLOAD_W-1:0] payload_t;
    typedef logic [31:0]          q16_16_t;

    // Little-endian layout: coord[0] occupies payload bytes 0..3, padding sits in the top nibble.
    typedef struct packed {
        logic [3:0]          pad;
        logic [11:0]         color;
        q16_16_t [8:0]       coord;
    } triangle_t;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_TYPE,
        ST_PAYLOAD,
        ST_CHECK,
        ST_OUT
    } rx_state_t;

    function automatic triangle_t unpack_triangle(input payload_t p);
        return triangle_t'(p);
    endfunction

endpackage

// File: rtl/packet_checksum.sv
// rtl/packet_checksum.sv - XOR checksum accumulator with load, accumulate and compare
module packet_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       accum,
    input  logic [7:0] data,
    output logic [7:0] acc,
    output logic       match
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'h00;
        end else if (load) begin
            acc <= data;
        end else if (accum) begin
            acc <= acc ^ data;
        end
    end

    assign match = (data == acc);

endmodule

// File: rtl/scene_packet_rx.sv
// rtl/scene_packet_rx.sv - byte-stream deframer emitting checked triangle payloads and scene_done
module scene_packet_rx
    import scene_link_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 scene_done,
    output logic [15:0]          tri_count,
    output logic [7:0]           err_count
);

    localparam logic [5:0] IDX_LAST = 6'(PAYLOAD_BYTES - 1);

    rx_state_t                     state;
    logic [5:0]                    idx;
    logic                          is_tri;
    logic [PAYLOAD_BYTES-1:0][7:0] shift_q;
    triangle_t                     out_tri_q;
    logic                          in_fire;
    logic [7:0]                    chk_acc;
    logic                          chk_match;

    assign in_fire     = in_valid & in_ready;
    assign out_payload = out_tri_q;

    packet_checksum u_checksum (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (in_fire && (state == ST_TYPE)),
        .accum (in_fire && (state == ST_PAYLOAD)),
        .data  (in_byte),
        .acc   (chk_acc),
        .match (chk_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            idx        <= 6'd0;
            is_tri     <= 1'b0;
            shift_q    <= '0;
            out_tri_q  <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            scene_done <= 1'b0;
            tri_count  <= 16'h0000;
            err_count  <= 8'h00;
        end else begin
            scene_done <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (in_fire && (in_byte == SYNC_BYTE)) begin
                        state <= ST_TYPE;
                    end
                end
                ST_TYPE: begin
                    if (in_fire) begin
                        if (in_byte == TYPE_TRI) begin
                            is_tri <= 1'b1;
                            idx    <= 6'd0;
                            state  <= ST_PAYLOAD;
                        end else if (in_byte == TYPE_EOF) begin
                            is_tri <= 1'b0;
                            state  <= ST_CHECK;
                        end else begin
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                            state <= ST_HUNT;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // SYNC_BYTE here is ordinary data; no resync inside a packet.
                    if (in_fire) begin
                        shift_q[idx] <= in_byte;
                        idx          <= idx + 6'd1;
                        if (idx == IDX_LAST) state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (in_fire) begin
                        if (!chk_match) begin
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                            state <= ST_HUNT;
                        end else if (is_tri) begin
                            out_tri_q <= unpack_triangle(payload_t'(shift_q));
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= ST_OUT;
                        end else begin
                            scene_done <= 1'b1;
                            tri_count  <= 16'h0000;
                            state      <= ST_HUNT;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        tri_count <= tri_count + 16'd1;
                        state     <= ST_HUNT;
                    end
                end
                default: begin
                    state    <= ST_HUNT;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/scene_packet_rx.md
Name: scene_packet_rx

Overview:
- Byte-stream deframer upstream of the triangle path. It accepts framed packets from the MCU link byte interface and verifies an XOR checksum.
- Each good triangle packet is emitted as one flat payload word on a valid/ready interface. That interface feeds the transform/render path in place of the ROM triangle feeder.
- An end-of-frame packet produces a one-cycle scene_done pulse.
- Runs in the render clock domain.

Parameters:
- PAYLOAD_BYTES, 38, triangle payload length in bytes (3 vertices x 3 q16_16 + 12-bit color, zero-padded to 304 bits).
- SYNC_BYTE, 8'hA5, packet start marker.
- TYPE_TRI, 8'h01, packet type: triangle.
- TYPE_EOF, 8'h02, packet type: end of scene, no payload.

Ports:
- clk  in  1  render clock.
- rst_n  in  1  asynchronous active-low reset.
- in_byte  in  8  incoming stream byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_payload  out  8*PAYLOAD_BYTES  triangle payload; first payload byte at [7:0], little-endian.
- out_valid  out  1  payload valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- scene_done  out  1  one-cycle pulse on a good EOF packet.
- tri_count  out  16  good triangles emitted since reset or last scene_done; wraps at 16'hFFFF.
- err_count  out  8  checksum/type errors since reset; saturates at 8'hFF.

Behaviour:
- Reset (async assert, sync release of logic state) drives these values:
  - state=HUNT, in_ready=1, out_valid=0, out_payload=0, scene_done=0, tri_count=0, err_count=0, checksum accumulator=0, byte index=0.
- Packet format: SYNC, TYPE, payload (PAYLOAD_BYTES for TRI, 0 for EOF), CHK.
  - CHK = XOR of TYPE and all payload bytes.
- States:
  - HUNT: discard bytes until SYNC_BYTE is accepted -> TYPE.
  - TYPE:
    - TYPE_TRI -> PAYLOAD, with acc=TYPE and idx=0.
    - TYPE_EOF -> CHECK, with acc=TYPE.
    - Any other value (including SYNC_BYTE) -> err_count+1 -> HUNT.
  - PAYLOAD: each accepted byte is written to payload shift register slot idx, acc^=byte, idx++. When idx==PAYLOAD_BYTES-1 is accepted -> CHECK.
  - CHECK: accept one byte.
    - byte==acc and type TRI -> load output register and set out_valid -> OUT.
    - byte==acc and type EOF -> scene_done=1 next cycle, tri_count=0 on the same edge -> HUNT.
    - byte!=acc -> err_count+1 -> HUNT; payload discarded, no output.
  - OUT: in_ready=0. When out_valid & out_ready: out_valid=0, tri_count+1 -> HUNT.
- Latency:
  - out_valid rises the cycle after the CHK byte handshake.
  - Minimum one bubble between packets; throughput is 1 byte/cycle within a packet.
- in_ready is 1 in HUNT, TYPE, PAYLOAD and CHECK, and 0 only in OUT.
- out_payload holds stable while out_valid=1 and out_ready=0; it changes only when loaded from CHECK.
- scene_done is exactly one cycle. tri_count reflects the clear on the cycle scene_done is high.
- in_valid=0 mid-packet: state and index hold indefinitely; there is no timeout.
- A SYNC_BYTE inside the payload is data, not a resync.
- Counter saturation: err_count stays at 8'hFF. tri_count wraps from 16'hFFFF to 0.
- Reset mid-packet or in OUT: immediate abort, all outputs return to reset values, partial packet lost.

Decomposition:
- Shared package scene_link_pkg holds:
  - SYNC/TYPE constants.
  - PAYLOAD_BYTES.
  - Typedef of the flat payload.
  - An unpack function payload->triangle_t used at the top level.
- One natural sub-module: packet_checksum (XOR accumulator with clear/load/compare). Otherwise a single FSM module.

Test Plan:
- Good TRI packet:
  - Stimulus: A5,01, payload 00..25 (0x00..0x25), CHK=01^XOR(00..25); out_ready=1.
  - Response: out_valid for one cycle the cycle after CHK; out_payload[7:0]=00, out_payload[303:296]=25; tri_count=1.
- Backpressure:
  - Stimulus: same packet with out_ready=0 for 10 cycles, then 1.
  - Response: out_valid held 10+ cycles; payload stable; in_ready=0 throughout; then HUNT, in_ready=1, tri_count=1.
- Bad checksum:
  - Stimulus: TRI packet with CHK flipped (^8'h01), followed by a good packet.
  - Response: no out_valid for the bad packet; err_count=1; the good packet is emitted normally.
- Unknown type and junk:
  - Stimulus: bytes 00,FF,A5,07,A5,02,02.
  - Response: err_count=1 from type 07; scene_done pulse after the final 02; tri_count=0.
- EOF resets count:
  - Stimulus: 3 good TRI packets, then A5,02,02.
  - Response: tri_count=3 before EOF; one-cycle scene_done; tri_count=0 on that cycle.
- Reset mid-payload:
  - Stimulus: rst_n low after payload byte 10, release, then a full good packet.
  - Response: all outputs at reset values during reset; only one out_valid, carrying the second packet's payload.
